// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered ALU between two requesters.
// Traps illegal opcodes (and optionally divide-by-zero) so they never reach the ALU.
module alu_arbiter #(
   parameter int DATA_W    = 16,
   parameter bit TRAP_DIV0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_opa,
   input  logic [DATA_W-1:0] req0_opb,
   input  logic [3:0]        req0_oper,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_opa,
   input  logic [DATA_W-1:0] req1_opb,
   input  logic [3:0]        req1_oper,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              alu_en,
   output logic [DATA_W-1:0] alu_operand_a,
   output logic [DATA_W-1:0] alu_operand_b,
   output logic [3:0]        alu_oper,
   input  logic [DATA_W-1:0] alu_q
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_t;

   state_t            state_q;
   logic              rr_q;          // 1 favours req1 on contention
   logic              id_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] resp_data_q;
   logic              alu_en_q;
   logic [DATA_W-1:0] alu_a_q;
   logic [DATA_W-1:0] alu_b_q;
   logic [3:0]        alu_oper_q;

   logic              gnt0;
   logic              gnt1;
   logic [DATA_W-1:0] sel_opa;
   logic [DATA_W-1:0] sel_opb;
   logic [3:0]        sel_oper;
   logic              legal;

   // Ready is gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n && state_q == IDLE) begin
         gnt0 = req0_valid && (!req1_valid || !rr_q);
         gnt1 = req1_valid && (!req0_valid || rr_q);
      end
      sel_opa  = gnt1 ? req1_opa  : req0_opa;
      sel_opb  = gnt1 ? req1_opb  : req0_opb;
      sel_oper = gnt1 ? req1_oper : req0_oper;
      legal    = (sel_oper != 4'd0) && (sel_oper <= 4'd12) &&
                 !(TRAP_DIV0 && sel_oper == 4'd12 && sel_opb == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         id_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         alu_en_q     <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_oper_q   <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt0 || gnt1) begin
                  id_q <= gnt1;
                  rr_q <= gnt0;
                  if (legal) begin
                     alu_a_q    <= sel_opa;
                     alu_b_q    <= sel_opb;
                     alu_oper_q <= sel_oper;
                     alu_en_q   <= 1'b1;
                     state_q    <= EXEC;
                  end else begin
                     resp_data_q  <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= RESP;
                  end
               end
            end
            EXEC: begin
               alu_en_q <= 1'b0;
               state_q  <= CAPT;
            end
            CAPT: begin
               resp_data_q  <= alu_q;
               resp_err_q   <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req0_ready    = gnt0;
   assign req1_ready    = gnt1;
   assign resp_valid    = resp_valid_q;
   assign resp_id       = id_q;
   assign resp_data     = resp_data_q;
   assign resp_err      = resp_err_q;
   assign alu_en        = alu_en_q;
   assign alu_operand_a = alu_a_q;
   assign alu_operand_b = alu_b_q;
   assign alu_oper      = alu_oper_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DW-1:0] req0_opa, req0_opb, req1_opa, req1_opb;
   logic [3:0]    req0_oper, req1_oper;
   logic          resp_valid, resp_ready, resp_id, resp_err;
   logic [DW-1:0] resp_data;
   logic          alu_en;
   logic [DW-1:0] alu_a, alu_b, alu_q;
   logic [3:0]    alu_op;

   logic          b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
   logic [DW-1:0] b_req0_opa, b_req0_opb, b_req1_opa, b_req1_opb;
   logic [3:0]    b_req0_oper, b_req1_oper;
   logic          b_resp_valid, b_resp_ready, b_resp_id, b_resp_err;
   logic [DW-1:0] b_resp_data;
   logic          b_alu_en;
   logic [DW-1:0] b_alu_a, b_alu_b, b_alu_q;
   logic [3:0]    b_alu_op;

   alu_arbiter #(.DATA_W(DW), .TRAP_DIV0(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
      .req0_opb(req0_opb), .req0_oper(req0_oper),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
      .req1_opb(req1_opb), .req1_oper(req1_oper),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_err(resp_err),
      .alu_en(alu_en), .alu_operand_a(alu_a), .alu_operand_b(alu_b),
      .alu_oper(alu_op), .alu_q(alu_q));

   alu_arbiter #(.DATA_W(DW), .TRAP_DIV0(1'b0)) dut_nodiv (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_opa(b_req0_opa),
      .req0_opb(b_req0_opb), .req0_oper(b_req0_oper),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_opa(b_req1_opa),
      .req1_opb(b_req1_opb), .req1_oper(b_req1_oper),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_id(b_resp_id),
      .resp_data(b_resp_data), .resp_err(b_resp_err),
      .alu_en(b_alu_en), .alu_operand_a(b_alu_a), .alu_operand_b(b_alu_b),
      .alu_oper(b_alu_op), .alu_q(b_alu_q));

   // Bench ALU: 1 add, 2 sub (B-A), 3 and, 4 or, 5 xor, 6 not A, 7 shl, 8 shr,
   // 9 inc, 10 dec, 11 mul, 12 div (A/B, all-ones when B is zero).
   function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return b - a;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return ~a;
         4'd7:    return a << b[3:0];
         4'd8:    return a >> b[3:0];
         4'd9:    return a + 16'd1;
         4'd10:   return a - 16'd1;
         4'd11:   return a * b;
         4'd12:   return (b == '0) ? '1 : a / b;
         default: return '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alu_q <= '0;
      else if (alu_en) alu_q <= alu_f(alu_op, alu_a, alu_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) b_alu_q <= '0;
      else if (b_alu_en) b_alu_q <= alu_f(b_alu_op, b_alu_a, b_alu_b);
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   typedef struct {
      logic          port;
      logic [DW-1:0] opa;
      logic [DW-1:0] opb;
      logic [3:0]    oper;
      logic [DW-1:0] exp_data;
      logic          exp_err;
   } vec_t;

   vec_t tbl[12];

   task automatic wait_grant(input logic port);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = port ? req1_ready : req0_ready;
      end
      chk("grant_wait", 32'(got), 32'd1);
   endtask

   task automatic wait_resp();
      logic got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = resp_valid;
      end
      chk("resp_wait", 32'(got), 32'd1);
   endtask

   task automatic do_txn(input int idx, input vec_t v);
      logic legal;
      legal = !v.exp_err;
      if (v.port) begin
         req1_valid = 1'b1; req1_opa = v.opa; req1_opb = v.opb; req1_oper = v.oper;
      end else begin
         req0_valid = 1'b1; req0_opa = v.opa; req0_opb = v.opb; req0_oper = v.oper;
      end
      resp_ready = 1'b1;
      wait_grant(v.port);
      chk($sformatf("tbl%0d_other_ready", idx),
          32'(v.port ? req0_ready : req1_ready), 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_alu_en", idx), 32'(alu_en), 32'(legal));
      if (legal) begin
         chk($sformatf("tbl%0d_alu_ops", idx), {alu_a, alu_b}, {v.opa, v.opb});
         chk($sformatf("tbl%0d_alu_oper", idx), 32'(alu_op), 32'(v.oper));
      end
      chk($sformatf("tbl%0d_valid_e1", idx), 32'(resp_valid), 32'(!legal));
      if (legal) begin
         @(negedge clk);
         chk($sformatf("tbl%0d_capt", idx), 32'({resp_valid, alu_en}), 32'd0);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid_e2", idx), 32'(resp_valid), 32'd1);
      end
      chk($sformatf("tbl%0d_data", idx), 32'(resp_data), 32'(v.exp_data));
      chk($sformatf("tbl%0d_err", idx), 32'(resp_err), 32'(v.exp_err));
      chk($sformatf("tbl%0d_id", idx), 32'(resp_id), 32'(v.port));
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
      chk({nm, "_resp"}, 32'({resp_valid, resp_id, resp_err}), 32'd0);
      chk({nm, "_data"}, 32'(resp_data), 32'd0);
      chk({nm, "_alu_en"}, 32'(alu_en), 32'd0);
      chk({nm, "_alu_ops"}, {alu_a, alu_b}, 32'd0);
      chk({nm, "_alu_oper"}, 32'(alu_op), 32'd0);
   endtask

   task automatic rand_req(output logic [DW-1:0] a, output logic [DW-1:0] b,
                           output logic [3:0] op);
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? '0 : 16'($urandom);
   endtask

   // Reference model state for the randomized phase
   logic          m_busy, m_legal, m_id, m_err, m_last;
   int            m_cnt;
   logic [DW-1:0] m_data, m_a, m_b;
   logic [3:0]    m_op;
   logic          e0, e1, ev, ea, got;

   initial begin
      tbl[0]  = '{1'b0, 16'd3,      16'd5,      4'd1,  16'd8,      1'b0};
      tbl[1]  = '{1'b1, 16'hFFFF,   16'd1,      4'd1,  16'h0000,   1'b0};
      tbl[2]  = '{1'b0, 16'd4,      16'd10,     4'd2,  16'd6,      1'b0};
      tbl[3]  = '{1'b1, 16'h00FF,   16'h0F0F,   4'd5,  16'h0FF0,   1'b0};
      tbl[4]  = '{1'b0, 16'd100,    16'd7,      4'd12, 16'd14,     1'b0};
      tbl[5]  = '{1'b0, 16'd9,      16'd0,      4'd12, 16'd0,      1'b1};
      tbl[6]  = '{1'b1, 16'd5,      16'd5,      4'd14, 16'd0,      1'b1};
      tbl[7]  = '{1'b0, 16'd5,      16'd5,      4'd0,  16'd0,      1'b1};
      tbl[8]  = '{1'b1, 16'd1,      16'd2,      4'd13, 16'd0,      1'b1};
      tbl[9]  = '{1'b0, 16'h1234,   16'd0,      4'd15, 16'd0,      1'b1};
      tbl[10] = '{1'b1, 16'h00FF,   16'h0F0F,   4'd3,  16'h000F,   1'b0};
      tbl[11] = '{1'b0, 16'd300,    16'd200,    4'd11, 16'hEA60,   1'b0};

      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_opa = '0; req0_opb = '0; req0_oper = 4'd0;
      req1_opa = '0; req1_opb = '0; req1_oper = 4'd0;
      resp_ready = 1'b0;
      b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_resp_ready = 1'b1;
      b_req0_opa = '0; b_req0_opb = '0; b_req0_oper = 4'd0;
      b_req1_opa = '0; b_req1_opb = '0; b_req1_oper = 4'd0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) do_txn(i, tbl[i]);

      // Reset while the ALU is being driven: request is dropped without a response
      req0_valid = 1'b1; req0_opa = 16'd3; req0_opb = 16'd5; req0_oper = 4'd1;
      resp_ready = 1'b1;
      wait_grant(1'b0);
      @(posedge clk); #1;
      chk("rst_exec_alu_en", 32'(alu_en), 32'd1);
      rst_n = 1'b0;
      req0_opa = 16'h00FF; req0_opb = 16'h0F0F; req0_oper = 4'd5;
      req1_valid = 1'b1; req1_opa = 16'd4; req1_opb = 16'd10; req1_oper = 4'd2;
      #1;
      chk_all_zero("rst_mid");
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_resp", 32'(resp_valid), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Continuous contention after reset: 0,1,0,1
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req0_ready | req1_ready;
         end
         chk($sformatf("cont%0d_grant", g), 32'({req1_ready, req0_ready}),
             (g % 2) ? 32'd2 : 32'd1);
         @(posedge clk); #1;
         wait_resp();
         chk($sformatf("cont%0d_id", g), 32'(resp_id), 32'(g % 2));
         chk($sformatf("cont%0d_data", g), 32'(resp_data), (g % 2) ? 32'd6 : 32'h0FF0);
         chk($sformatf("cont%0d_err", g), 32'(resp_err), 32'd0);
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure in RESP
      req0_valid = 1'b1; req0_opa = 16'd3; req0_opb = 16'd5; req0_oper = 4'd1;
      resp_ready = 1'b0;
      wait_grant(1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_opa = 16'd7; req1_opb = 16'd8; req1_oper = 4'd1;
      wait_resp();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold", {12'd0, resp_valid, resp_id, resp_err, resp_data, req0_ready,
                         req1_ready}, {12'd0, 3'b100, 16'd8, 2'b00});
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_before_hs", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_ready_after_hs", 32'(req1_ready), 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_resp();
      chk("bp_req1_resp", 32'({resp_id, resp_err, resp_data}), {15'd0, 2'b10, 16'd15});
      @(posedge clk); #1;

      // Div-by-zero is issued when trapping is disabled
      b_req0_valid = 1'b1; b_req0_opa = 16'd50; b_req0_opb = 16'd0; b_req0_oper = 4'd12;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = b_req0_ready;
      end
      chk("nodiv_grant", 32'({got, b_req1_ready}), 32'd2);
      @(posedge clk); #1;
      b_req0_valid = 1'b0;
      @(negedge clk);
      chk("nodiv_alu_en", 32'(b_alu_en), 32'd1);
      chk("nodiv_alu_ops", {b_alu_a, 12'd0, b_alu_op}, {16'd50, 16'd12});
      chk("nodiv_alu_b", 32'(b_alu_b), 32'd0);
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = b_resp_valid;
      end
      chk("nodiv_resp", 32'({got, b_resp_id, b_resp_err, b_resp_data}), {15'd0, 3'b100, 16'hFFFF});
      @(posedge clk); #1;

      // Randomized traffic against the transaction-level model
      m_busy = 1'b0; m_last = 1'b1; m_cnt = 0; m_legal = 1'b0; m_id = 1'b0;
      m_err = 1'b0; m_data = '0; m_a = '0; m_b = '0; m_op = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!req0_valid && $urandom_range(0, 1) == 1) begin
            req0_valid = 1'b1; rand_req(req0_opa, req0_opb, req0_oper);
         end
         if (!req1_valid && $urandom_range(0, 1) == 1) begin
            req1_valid = 1'b1; rand_req(req1_opa, req1_opb, req1_oper);
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (m_busy) m_cnt++;
         e0 = !m_busy && req0_valid && (!req1_valid || m_last);
         e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
         chk("rnd_ready", 32'({req1_ready, req0_ready}), 32'({e1, e0}));
         ev = m_busy && (m_cnt >= (m_legal ? 3 : 1));
         chk("rnd_resp_valid", 32'(resp_valid), 32'(ev));
         if (ev) chk("rnd_resp", 32'({m_id, m_err, m_data}), 32'({resp_id, resp_err, resp_data}));
         ea = m_busy && m_legal && m_cnt == 1;
         chk("rnd_alu_en", 32'(alu_en), 32'(ea));
         if (ea) chk("rnd_alu_ops", {alu_a, alu_b}, {m_a, m_b});
         if (ev && resp_ready) m_busy = 1'b0;
         if (e0 || e1) begin
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_id    = e1;
            m_last  = e1;
            m_a     = e1 ? req1_opa  : req0_opa;
            m_b     = e1 ? req1_opb  : req0_opb;
            m_op    = e1 ? req1_oper : req0_oper;
            m_legal = (m_op >= 4'd1) && (m_op <= 4'd12) && !(m_op == 4'd12 && m_b == '0);
            m_err   = !m_legal;
            m_data  = m_legal ? alu_f(m_op, m_a, m_b) : '0;
         end
         @(posedge clk); #1;
         if (e0) req0_valid = 1'b0;
         if (e1) req1_valid = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between two requesters (e.g. instruction-issue and address-generation ports) using round-robin arbitration and valid/ready handshakes. It latches the winning request, sequences the ALU enable and operands, captures the result and returns it on one shared response channel tagged with the requester ID. Illegal opcodes and divide-by-zero are trapped before issue, so the ALU never sees them.

## Interface
- DATA_W, 16, operand/result width; must match the ALU (16).
- TRAP_DIV0, 1, when 1, oper 12 with opb==0 is trapped; when 0, it is issued to the ALU.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when ANDed with valid.
- req0_opa, req0_opb / req1_opa, req1_opb  in  DATA_W  operands.
- req0_oper / req1_oper  in  4  ALU opcode (1..12 legal).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester index of the response.
- resp_data  out  DATA_W  result, or 0 on error.
- resp_err  out  1  request was trapped (illegal opcode or div0).
- alu_en  out  1  ALU enable.
- alu_operand_a, alu_operand_b  out  DATA_W  ALU operand A and operand B.
- alu_oper  out  4  ALU opcode.
- alu_q  in  DATA_W  ALU registered result.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: req*_ready is combinational and is high only for the arbitration winner among the asserted valids. Priority: the requester not granted last wins; with one requester valid, it wins. The rr pointer resets to favour req0.
- On acceptance:
  - latch opa, opb, oper and id, and toggle the rr pointer to point away from the winner.
  - Legal op (1..12, and not trapped div0): go to EXEC.
  - Illegal op (0, 13..15) or trapped div0: resp_data<=0, resp_err<=1, go to RESP.
- EXEC: alu_en=1 and alu_* driven from the latched request for exactly one cycle; go to CAPT.
- CAPT: resp_data<=alu_q, resp_err<=0; go to RESP.
- RESP: resp_valid=1. resp_data, resp_id and resp_err hold stable until resp_ready. On resp_valid&resp_ready, go to IDLE.
- Operands pass unmodified: opa→operandA, opb→operandB. Operation ordering semantics (e.g. sub = B−A) belong to the ALU.
- alu_operand_*/alu_oper are registered and hold their last values outside EXEC. alu_en is 0 in every state except EXEC.
- Requesters must hold valid and payload stable until ready. Only one request is in flight at a time.

## Timing
- Reset (async assert, sync release): state=IDLE, rr pointer favours req0. All outputs are 0: req*_ready, resp_valid, resp_id, resp_data, resp_err, alu_en, alu_operand_a, alu_operand_b, alu_oper.
- Legal op: accept edge E0 → alu_en high in cycle E0..E1 → ALU updates q at E1 → captured at E2 → resp_valid high from E2.
- Trapped op: resp_valid high from E0+1.
- Throughput: req*_ready is low from the accept edge until the cycle after the resp handshake. Minimum spacing is 4 cycles per legal op with resp_ready tied high, and 2 cycles per trapped op.
- Simultaneous valids: exactly one ready is asserted. Grants alternate 0,1,0,1 under continuous contention.
- A new request arriving while in RESP is not accepted until back in IDLE. resp_ready low stalls indefinitely with no data change.
- rst_n asserted mid-operation: the in-flight request is dropped, alu_en drops immediately, and no response is produced.

## Test plan
- Single add: req0 opa=3, opb=5, oper=1; resp_ready=1 → alu_en pulses 1 cycle with alu_operand_a=3, alu_operand_b=5; resp_valid 2 cycles after accept; resp_data=8, resp_id=0, resp_err=0.
- Contention: both requesters valid continuously; req0 xor 0x00FF^0x0F0F, req1 sub opb=10, opa=4 → grants alternate 0,1,0,1; responses 0x0FF0/id0 and 6/id1 in grant order.
- Traps: oper=12 with opb=0, then oper=14 → no alu_en pulse; resp_valid 1 cycle after accept; resp_data=0, resp_err=1. With TRAP_DIV0=0, the same div request issues to the ALU.
- Backpressure: resp_ready held low 5 cycles in RESP → resp_valid, resp_data, resp_id and resp_err stable; req*_ready stays 0; accept occurs only after the handshake.
- Reset mid-op: rst_n low during EXEC → alu_en=0 at once; all outputs 0; after release, the first request is granted to req0 when both are valid.
